// File: rtl/RISCV_MCU_CONFIG.sv
// MCU-wide configuration constants and shared types (boot ROM window, response record).
package RISCV_MCU_CONFIG;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int ROM_ADDR_WIDTH = 12;
    localparam logic [31:0] ROM_START_ADDR = 32'h0000_8000;
    localparam logic [31:0] ROM_END_ADDR   = ROM_START_ADDR + (32'd4 << ROM_ADDR_WIDTH);
    localparam int ROM_RESP_DEPTH = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rom_resp_t;

    localparam int ROM_RESP_W = $bits(rom_resp_t);

endpackage

// File: rtl/rom_resp_fifo.sv
// Small synchronous FIFO holding ROM fetch responses until the consumer accepts them.
module rom_resp_fifo
    import RISCV_MCU_CONFIG::*;
#(
    parameter int DEPTH = ROM_RESP_DEPTH,
    parameter int WIDTH = ROM_RESP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/boot_rom_fetch_if.sv
// Boot ROM instruction-fetch front end: window decode, 1-cycle ROM access, credit-limited response buffer.
// Optional build macro ROM_RANDOM_STALL_EN adds LFSR-driven grant drops for latency stress in simulation.
module boot_rom_fetch_if
    import RISCV_MCU_CONFIG::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int ROM_AW     = ROM_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE = ADDR_WIDTH'(ROM_START_ADDR),
    parameter int RESP_DEPTH = ROM_RESP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    input  logic                  instr_rready_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    output logic                  rom_en_o,
    output logic [ROM_AW-1:0]     rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_rdata_i
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ROM_END = ROM_BASE + (ADDR_WIDTH'(4) << ROM_AW);

    logic [CW-1:0] r_cnt;
    logic          r_inflight;
    logic          r_inflight_err;
    logic          w_hit;
    logic          w_stall;
    logic          w_pop;
    logic          w_fifo_push;
    logic          w_fifo_pop;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    rom_resp_t     w_new_resp;
    rom_resp_t     w_head_resp;
    rom_resp_t     w_out_resp;

    assign w_hit = (instr_addr_i >= ROM_BASE) && (instr_addr_i < ROM_END)
                   && (instr_addr_i[1:0] == 2'b00);

`ifdef ROM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16/14/13/11
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // A pop in the same cycle frees a credit for a new grant.
    assign w_pop       = instr_rvalid_o & instr_rready_i;
    assign instr_gnt_o = instr_req_i & ~w_stall & ((r_cnt - CW'(w_pop)) < CW'(RESP_DEPTH));
    assign rom_en_o    = instr_gnt_o & w_hit;
    assign rom_addr_o  = rom_en_o ? ROM_AW'((instr_addr_i - ROM_BASE) >> 2) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_inflight     <= 1'b0;
            r_inflight_err <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + CW'(instr_gnt_o) - CW'(w_pop);
            r_inflight     <= instr_gnt_o;
            r_inflight_err <= instr_gnt_o & ~w_hit;
        end
    end

    always_comb begin
        w_new_resp = '0;
        if (r_inflight) begin
            w_new_resp.rdata = r_inflight_err ? 32'h0 : 32'(rom_rdata_i);
            w_new_resp.err   = r_inflight_err;
        end
    end

    // Empty FIFO lets the in-flight response fall through; otherwise it queues behind the head.
    assign w_fifo_push = r_inflight & ~(w_fifo_empty & instr_rready_i);
    assign w_fifo_pop  = ~w_fifo_empty & instr_rready_i;

    rom_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (ROM_RESP_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .din   (w_new_resp),
        .dout  (w_head_resp),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign w_out_resp     = w_fifo_empty ? w_new_resp : w_head_resp;
    assign instr_rvalid_o = w_fifo_empty ? r_inflight : 1'b1;
    assign instr_rdata_o  = DATA_WIDTH'(w_out_resp.rdata);
    assign instr_err_o    = w_out_resp.err;

endmodule

// File: tb/tb_boot_rom_fetch_if.sv
// Scoreboard bench for boot_rom_fetch_if: driver pushes expected responses on grant, monitor pops on rvalid&rready.
module tb_boot_rom_fetch_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic        instr_rready_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        rom_en_o;
    logic [11:0] rom_addr_o;
    logic [31:0] rom_rdata_i = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          m_cnt = 0;
    int          n_issued = 0;
    logic [32:0] sb [$];

`ifdef ROM_RANDOM_STALL_EN
    localparam int N_RAND = 1000;
`else
    localparam int N_RAND = 200;
`endif

    always #5 clk = ~clk;

    boot_rom_fetch_if dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rready_i (instr_rready_i),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .rom_en_o       (rom_en_o),
        .rom_addr_o     (rom_addr_o),
        .rom_rdata_i    (rom_rdata_i)
    );

    function automatic logic [31:0] rom_word(input logic [11:0] idx);
        return (idx == 12'h000) ? 32'h0000_0013 : {20'hA5A50, idx};
    endfunction

    always @(posedge clk) begin
        if (rom_en_o) rom_rdata_i <= rom_word(rom_addr_o);
    end

`ifdef ROM_RANDOM_STALL_EN
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
    function automatic logic stall_model();
        return (m_lfsr[1:0] == 2'b00);
    endfunction
`else
    function automatic logic stall_model();
        return 1'b0;
    endfunction
`endif

    function automatic logic hit(input logic [31:0] a);
        return (a >= 32'h8000) && (a < 32'hC000) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [32:0] expect_resp(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h8000;
        return hit(a) ? {rom_word(off[13:2]), 1'b0} : {32'h0, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; exp_gnt < 0 means no hand-computed grant expectation.
    task automatic cyc(input logic req, input logic [31:0] addr, input logic rdy, input int exp_gnt);
        logic pop_m, gnt_m, stall_m;
        logic [31:0] off;
        @(negedge clk);
        instr_req_i = req;
        instr_addr_i = addr;
        instr_rready_i = rdy;
        #3;
        stall_m = stall_model();
        pop_m = (m_cnt != 0) && rdy;
        gnt_m = req && ((m_cnt - int'(pop_m)) < 2) && !stall_m;
        chk("rvalid", 32'(instr_rvalid_o), 32'(m_cnt != 0));
        chk("gnt", 32'(instr_gnt_o), 32'(gnt_m));
        if (exp_gnt >= 0 && !stall_m) chk("gnt_hand", 32'(instr_gnt_o), 32'(exp_gnt));
        chk("rom_en", 32'(rom_en_o), 32'(gnt_m && hit(addr)));
        if (gnt_m && hit(addr)) begin
            off = addr - 32'h8000;
            chk("rom_addr", 32'(rom_addr_o), 32'(off[13:2]));
        end
        if (gnt_m) begin
            sb.push_back(expect_resp(addr));
            n_issued++;
        end
        m_cnt = m_cnt + int'(gnt_m) - int'(pop_m);
        $display("cyc t=%0t req=%0b addr=%08h rdy=%0b gnt=%0b rvalid=%0b rdata=%08h err=%0b",
                 $time, req, addr, rdy, instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o);
    endtask

    // Monitor: compares every accepted response against the scoreboard head.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && dut.u_fifo.push && dut.u_fifo.full) begin
                n_checks++;
                n_fail++;
                $display("FAIL fifo_overflow: push while full at %0t", $time);
            end
            if (rst_n && instr_rvalid_o && instr_rready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got %08h/%0b expected none", instr_rdata_o, instr_err_o);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", instr_rdata_o, e[32:1]);
                    chk("resp_err", 32'(instr_err_o), 32'(e[0]));
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int start;
        #12;
        chk("rst_gnt", 32'(instr_gnt_o), 32'h0);
        chk("rst_rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("rst_rdata", instr_rdata_o, 32'h0);
        chk("rst_err", 32'(instr_err_o), 32'h0);
        chk("rst_rom_en", 32'(rom_en_o), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch of word 0
        cyc(1'b1, 32'h8000, 1'b1, 1);
        cyc(1'b0, 32'h0, 1'b1, 0);

        // Window edges: last word, then three misses
        cyc(1'b1, 32'hBFFC, 1'b1, 1);
        cyc(1'b1, 32'hC000, 1'b1, 1);
        cyc(1'b1, 32'h7FFC, 1'b1, 1);
        cyc(1'b1, 32'h8002, 1'b1, 1);
        cyc(1'b0, 32'h0, 1'b1, 0);

        // Streaming
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h8000 + 32'(4 * i), 1'b1, 1);
        cyc(1'b0, 32'h0, 1'b1, 0);

        // Back-pressure: two grants, then none until the first pop
        cyc(1'b1, 32'h8020, 1'b0, 1);
        cyc(1'b1, 32'h8024, 1'b0, 1);
        cyc(1'b1, 32'h8028, 1'b0, 0);
        cyc(1'b1, 32'h8028, 1'b0, 0);
        cyc(1'b1, 32'h8028, 1'b1, 1);
        cyc(1'b1, 32'h802C, 1'b1, 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 0);

        // Reset with two responses outstanding
        cyc(1'b1, 32'h8040, 1'b0, 1);
        cyc(1'b1, 32'h8044, 1'b0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        instr_req_i = 1'b0;
        #1;
        chk("rst_async_rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("rst_async_gnt", 32'(instr_gnt_o), 32'h0);
        sb.delete();
        m_cnt = 0;
        cyc(1'b0, 32'h0, 1'b1, 0);
        cyc(1'b0, 32'h0, 1'b1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h8010, 1'b1, 1);
        cyc(1'b0, 32'h0, 1'b1, 0);
        cyc(1'b0, 32'h0, 1'b1, 0);

        // Random ordered stream with random back-pressure
        start = n_issued;
        for (int c = 0; c < 20000 && (n_issued - start) < N_RAND; c++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'hC000 + 32'(4 * $urandom_range(0, 15));
                1:       a = 32'h8001 + 32'($urandom_range(0, 2));
                2:       a = 32'h7FFC;
                default: a = 32'h8000 + 32'(4 * $urandom_range(0, 4095));
            endcase
            cyc($urandom_range(0, 4) != 0, a, $urandom_range(0, 3) != 0, -1);
        end
        chk("rand_stream_len", 32'(n_issued - start), 32'(N_RAND));

        for (int i = 0; i < 50 && sb.size() != 0; i++) cyc(1'b0, 32'h0, 1'b1, 0);
        chk("drain_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_rom_fetch_if.md
Name: boot_rom_fetch_if

Overview:
- Instruction-side front end of the boot ROM. Sits between the core instruction fetch port and the synchronous ROM macro.
- Decodes the fetch address against the ROM window defined by ROM_START_ADDR and ROM_ADDR_WIDTH in the RISCV_MCU_CONFIG package.
- Drives the 1-cycle-latency ROM and buffers responses in a small FIFO so the consumer can back-pressure rvalid.
- Returns an error response for out-of-window or misaligned fetches.

Parameters:
ADDR_WIDTH, 32 (AXI_ADDR_WIDTH), core fetch address width
DATA_WIDTH, 32, fetch data width
ROM_AW, 12 (ROM_ADDR_WIDTH), ROM word-address width
ROM_BASE, 32'h8000 (ROM_START_ADDR), first byte address of the ROM window
RESP_DEPTH, 2, maximum granted-but-unconsumed requests (in-flight plus buffered)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_addr_i  in  ADDR_WIDTH  fetch byte address
instr_gnt_o  out  1  request accepted this cycle
instr_rvalid_o  out  1  response valid
instr_rready_i  in  1  consumer accepts response
instr_rdata_o  out  DATA_WIDTH  fetched word
instr_err_o  out  1  response is an error (qualified by rvalid)
rom_en_o  out  1  ROM read enable
rom_addr_o  out  ROM_AW  ROM word address
rom_rdata_i  in  DATA_WIDTH  ROM data, valid one cycle after rom_en_o

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: gnt=0, rvalid=0, rdata=0, err=0, rom_en=0, rom_addr=0. The credit counter, FIFO pointers and the in-flight flag clear.
- Window: hit = addr >= ROM_BASE, addr < ROM_BASE + (4<<ROM_AW), and addr[1:0]==0. Defaults give 0x8000..0xBFFF.
- Credit counter cnt (0..RESP_DEPTH) = in-flight + FIFO occupancy.
- Grant: instr_gnt_o = req & (cnt < RESP_DEPTH), combinational. Release the grant when cnt - pop < RESP_DEPTH, i.e. a same-cycle pop frees a credit.
- Granted hit at cycle T:
  - rom_en_o=1 and rom_addr_o=(addr-ROM_BASE)>>2 in cycle T.
  - ROM data arrives at T+1.
- Granted miss at cycle T:
  - rom_en_o=0.
  - Error response (rdata=0, err=1) becomes available at T+1, so hits and misses have identical timing.
- Response path at T+1:
  - If the FIFO is empty, the response falls through combinationally: rvalid=1, rdata/err come from the ROM/error path.
  - If not accepted (rready=0), it is written into the FIFO.
  - If the FIFO is non-empty, rvalid/rdata/err come from the FIFO head, and the new response is pushed behind it.
- Pop condition: rvalid & rready.
- Counter update: cnt_next = cnt + gnt - pop. Simultaneous grant and pop leaves cnt unchanged.
- Ordering: responses are strictly in grant order. Never drop or duplicate a response.
- Throughput: with rready held high, one response per cycle (back-to-back grants, 1-cycle latency).
- Full (cnt==RESP_DEPTH): gnt=0 regardless of req. The address is ignored until a credit frees.
- FIFO overflow is structurally impossible. The bench asserts on it.
- Request stability: req/addr are not required to be held without gnt; each cycle is evaluated independently.
- Reset mid-operation: all in-flight and buffered responses are discarded. rvalid drops asynchronously; the consumer restarts fetching.

Optional Feature:
- Macro: ROM_RANDOM_STALL_EN.
- When defined:
  - A 16-bit LFSR (seed 16'hACE1, polynomial x^16+x^14+x^13+x^11+1) advances every cycle.
  - When lfsr[1:0]==2'b00, gnt is forced to 0 in that cycle.
  - The fetch-latency stress is for simulation only.
- When undefined: no LFSR logic exists and grant follows the base rule.

Decomposition:
- Package RISCV_MCU_CONFIG gains:
  - ROM_END_ADDR = ROM_START_ADDR + (4<<ROM_ADDR_WIDTH).
  - ROM_RESP_DEPTH = 2.
  - Typedef rom_resp_t, a packed struct {logic [31:0] rdata; logic err;}.
- One sub-module: rom_resp_fifo, a parameterised synchronous FIFO of rom_resp_t with depth RESP_DEPTH, push/pop/empty/full, and an async active-low reset.

Test Plan:
1. Single fetch: addr 0x8000, ROM word0 = 0x00000013. Expect gnt at T, rvalid at T+1 with rdata 0x00000013, err=0, rom_addr=0.
2. Window edges:
   - 0xBFFC gives rom_addr=0xFFF, err=0.
   - 0xC000, 0x7FFC and 0x8002 each give an error response with rdata=0, err=1 and rom_en=0.
3. Streaming: 8 sequential fetches from 0x8000 with rready=1. Expect gnt every cycle, 8 responses in consecutive cycles, in order.
4. Back-pressure: rready=0, req held. Expect exactly 2 grants, then gnt=0. Raise rready: responses drain in order and gnt resumes the same cycle as the first pop.
5. Reset mid-burst: assert rst_n=0 with cnt=2. Expect rvalid=0 immediately. After release, the first fetch completes normally, with no stale response.
6. With ROM_RANDOM_STALL_EN: a 1000-fetch random stream produces a correct, ordered response stream. Grant-drop cycles match the LFSR reference model.
